// File: rtl/serial_word_arbiter.sv
// serial_word_arbiter: round-robin arbiter that grants one serial requester
// at a time and assembles its LSB-first bits into a parallel word.
// Ports: clk, rst (sync, active-high); req/serial_valid/serial_data [n_ch];
//   grant [n_ch] one-hot or zero; parallel_valid/parallel_data/parallel_ch
//   report a finished word; abort pulses when a granted word times out.
// Optional: define SERIAL_ARB_TIMEOUT_EN to release a channel that stays
//   silent for `timeout` consecutive cycles; otherwise abort is tied to 0.
module serial_word_arbiter #(
    parameter int width   = 8,
    parameter int n_ch    = 4,
    parameter int timeout = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [n_ch-1:0]         req,
    input  logic [n_ch-1:0]         serial_valid,
    input  logic [n_ch-1:0]         serial_data,
    output logic [n_ch-1:0]         grant,
    output logic                    parallel_valid,
    output logic [width-1:0]        parallel_data,
    output logic [$clog2(n_ch)-1:0] parallel_ch,
    output logic                    abort
);

    localparam int CHW = $clog2(n_ch);
    localparam int CW  = $clog2(width);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CHW-1:0]    cur;
    logic [CHW-1:0]    last;
    logic [CHW-1:0]    pick;
    logic [width-1:0]  shreg;
    logic [width-1:0]  word_nxt;
    logic [n_ch-1:0]   onehot;
    logic              bit_v;
    logic              bit_d;
    logic              last_bit;
    int                idx;

    assign bit_v    = serial_valid[cur];
    assign bit_d    = serial_data[cur];
    assign last_bit = (cnt == CW'(width - 1));
    assign onehot   = {{(n_ch-1){1'b0}}, 1'b1} << pick;

    // Scan from the farthest candidate down to the nearest so the last
    // write wins: the first requester after `last` ends up selected.
    always_comb begin
        pick = last;
        idx  = 0;
        for (int i = n_ch; i >= 1; i--) begin
            idx = (int'(last) + i) % n_ch;
            if (req[CHW'(idx)]) begin
                pick = CHW'(idx);
            end
        end
    end

    always_comb begin
        word_nxt      = shreg;
        word_nxt[cnt] = bit_d;
    end

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(timeout + 1);
    logic [TW-1:0] idle_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= '0;
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
            parallel_ch    <= '0;
            cnt            <= '0;
            cur            <= '0;
            last           <= CHW'(n_ch - 1);
            shreg          <= '0;
`ifdef SERIAL_ARB_TIMEOUT_EN
            abort          <= 1'b0;
            idle_cnt       <= '0;
`endif
        end else begin
            parallel_valid <= 1'b0;
`ifdef SERIAL_ARB_TIMEOUT_EN
            abort          <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= onehot;
                        cur   <= pick;
                        cnt   <= '0;
                        state <= COLLECT;
`ifdef SERIAL_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (bit_v) begin
                        shreg <= word_nxt;
`ifdef SERIAL_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (last_bit) begin
                            parallel_valid <= 1'b1;
                            parallel_data  <= word_nxt;
                            parallel_ch    <= cur;
                            grant          <= '0;
                            last           <= cur;
                            cnt            <= '0;
                            state          <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
`ifdef SERIAL_ARB_TIMEOUT_EN
                    else if (idle_cnt == TW'(timeout - 1)) begin
                        abort    <= 1'b1;
                        grant    <= '0;
                        last     <= cur;
                        cnt      <= '0;
                        idle_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SERIAL_ARB_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = (timeout != 0);
    assign abort          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_arbiter.sv
// Randomised + directed bench for serial_word_arbiter with a word-level
// reference model; outputs are compared every cycle on the falling edge.
module tb_serial_word_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 16;
`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] serial_valid;
    logic [N-1:0] serial_data;
    logic [N-1:0] grant;
    logic         parallel_valid;
    logic [W-1:0] parallel_data;
    logic [1:0]   parallel_ch;
    logic         abort;

    serial_word_arbiter #(.width(W), .n_ch(N), .timeout(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .grant          (grant),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ch    (parallel_ch),
        .abort          (abort)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit chk     = 1'b0;

    // reference model state
    int           m_owner = -1;
    int           m_nbits = 0;
    int           m_idle  = 0;
    int           m_last  = N - 1;
    logic [W-1:0] m_word  = '0;
    logic [N-1:0] e_grant = '0;
    logic         e_pv    = 1'b0;
    logic [W-1:0] e_pd    = '0;
    logic [1:0]   e_pch   = '0;
    logic         e_ab    = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_nbits = 0; m_idle = 0; m_last = N - 1;
            e_grant = '0; e_pv = 1'b0; e_pd = '0; e_pch = '0; e_ab = 1'b0;
        end else begin
            e_pv = 1'b0;
            e_ab = 1'b0;
            if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (m_last + i) % N;
                    if (m_owner < 0 && req[c]) m_owner = c;
                end
                if (m_owner >= 0) begin
                    e_grant = N'(1 << m_owner);
                    m_nbits = 0;
                    m_idle  = 0;
                end
            end else if (serial_valid[m_owner]) begin
                m_word[m_nbits] = serial_data[m_owner];
                m_nbits++;
                m_idle = 0;
                if (m_nbits == W) begin
                    e_pv    = 1'b1;
                    e_pd    = m_word;
                    e_pch   = 2'(m_owner);
                    e_grant = '0;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_idle++;
                if (TO_EN && m_idle == TO) begin
                    e_ab    = 1'b1;
                    e_grant = '0;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("grant", 32'(grant), 32'(e_grant));
            check("parallel_valid", 32'(parallel_valid), 32'(e_pv));
            check("parallel_data", 32'(parallel_data), 32'(e_pd));
            check("parallel_ch", 32'(parallel_ch), 32'(e_pch));
            check("abort", 32'(abort), 32'(e_ab));
        end
    end

    task automatic cyc(input logic r, input logic [N-1:0] q,
                       input logic [N-1:0] v, input logic [N-1:0] d);
        rst = r; req = q; serial_valid = v; serial_data = d;
        @(posedge clk);
        model_step();
        chk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input int ch, input logic [W-1:0] w,
                             input logic [N-1:0] q);
        for (int k = 0; k < W; k++) begin
            cyc(1'b0, q, N'(1 << ch), {N{w[k]}});
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; serial_valid = '0; serial_data = '0;
        @(negedge clk);
        cyc(1'b1, '0, '0, '0);
        cyc(1'b1, '0, '0, '0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_pv", 32'(parallel_valid), 32'h0);
        check("rst_pd", 32'(parallel_data), 32'h0);
        check("rst_abort", 32'(abort), 32'h0);

        // single word from ch0
        cyc(1'b0, 4'b0001, '0, '0);
        check("w0_grant", 32'(grant), 32'h1);
        send_word(0, 8'h4D, 4'b0000);
        check("w0_pv", 32'(parallel_valid), 32'h1);
        check("w0_pd", 32'(parallel_data), 32'h4D);
        check("w0_pch", 32'(parallel_ch), 32'h0);
        cyc(1'b0, '0, '0, '0);
        check("w0_hold", 32'(parallel_data), 32'h4D);
        check("w0_pv_low", 32'(parallel_valid), 32'h0);

        // round robin with all requesting
        cyc(1'b1, '0, '0, '0);
        for (int w = 0; w < 5; w++) begin
            logic [N-1:0] eg;
            eg = N'(1 << (w % N));
            cyc(1'b0, 4'hF, '0, '0);
            check("rr_grant", 32'(grant), 32'(eg));
            send_word(w % N, 8'hA5, 4'hF);
            check("rr_pd", 32'(parallel_data), 32'hA5);
            check("rr_gap", 32'(grant), 32'h0);
        end

        // ch1 sends zeros with gaps while ch0/ch2 chatter with ones
        cyc(1'b0, 4'b0010, '0, '0);
        check("iso_grant", 32'(grant), 32'h2);
        begin
            int sent = 0;
            int n    = 0;
            logic tog = 1'b0;
            while (sent < W && n < 100) begin
                logic acc;
                acc = 1'($urandom % 2);
                tog = ~tog;
                cyc(1'b0, '0, {1'b0, tog, acc, tog}, 4'b1101);
                if (acc) sent++;
                n++;
            end
        end
        check("iso_pv", 32'(parallel_valid), 32'h1);
        check("iso_pd", 32'(parallel_data), 32'h00);
        check("iso_pch", 32'(parallel_ch), 32'h1);

        // reset mid-word
        cyc(1'b0, 4'b0100, '0, '0);
        check("rm_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 5; k++) cyc(1'b0, 4'b0100, 4'b0100, 4'hF);
        cyc(1'b1, 4'hF, 4'hF, 4'hF);
        check("rm_pv", 32'(parallel_valid), 32'h0);
        check("rm_grant0", 32'(grant), 32'h0);
        cyc(1'b0, 4'hF, '0, '0);
        check("rm_next", 32'(grant), 32'h1);

        // timeout scenario
        cyc(1'b1, '0, '0, '0);
        cyc(1'b0, 4'b0001, '0, '0);
        send_word(0, 8'h4D, 4'b0000);
        cyc(1'b0, 4'b1000, '0, '0);
        check("to_grant", 32'(grant), 32'h8);
        for (int k = 0; k < 3; k++) cyc(1'b0, '0, 4'b1000, 4'hF);
`ifdef SERIAL_ARB_TIMEOUT_EN
        for (int k = 0; k < TO - 1; k++) cyc(1'b0, '0, '0, '0);
        check("to_pre_abort", 32'(abort), 32'h0);
        check("to_pre_grant", 32'(grant), 32'h8);
        cyc(1'b0, '0, '0, '0);
        check("to_abort", 32'(abort), 32'h1);
        check("to_grant0", 32'(grant), 32'h0);
        check("to_pd", 32'(parallel_data), 32'h4D);
        cyc(1'b0, 4'b1001, '0, '0);
        check("to_next", 32'(grant), 32'h1);
`else
        for (int k = 0; k < 100; k++) begin
            cyc(1'b0, '0, '0, '0);
            check("nto_abort", 32'(abort), 32'h0);
            check("nto_grant", 32'(grant), 32'h8);
        end
`endif

        // randomized traffic
        cyc(1'b1, '0, '0, '0);
        for (int n = 0; n < 4000; n++) begin
            int mode;
            logic [N-1:0] v;
            mode = (n / 200) % 3;
            case (mode)
                0:       v = N'($urandom | $urandom);
                1:       v = N'($urandom & $urandom & $urandom);
                default: v = ((n % 50) < 25) ? N'($urandom) : '0;
            endcase
            cyc(($urandom % 400) == 0, N'($urandom), v, N'($urandom));
        end

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
